// File: rtl/pipe_pkg.sv
// pipe_pkg: shared EX/MEM control-bit indices and the default-width bundle type.
package pipe_pkg;
  localparam int CTRL_W = 5;
  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_MEMTOREG = 1;
  localparam int CTRL_MEMREAD = 2;
  localparam int CTRL_MEMWRITE = 3;
  localparam int CTRL_FWD = 4;
  typedef struct packed {
    logic [31:0] alu_out;
    logic [31:0] store_data;
    logic [4:0] rw;
    logic [CTRL_W-1:0] ctrl;
  } exmem_t;
endpackage

// File: rtl/skid_buffer_2.sv
// skid_buffer_2: generic 2-entry valid/ready buffer, falling-edge state, registered in_ready.
module skid_buffer_2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  logic skid_valid;
  logic [W-1:0] skid_data;
  logic acc, ret;
  assign in_ready = ~skid_valid;
  assign acc = in_valid & ~skid_valid;
  assign ret = out_valid & out_ready;
  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      skid_valid <= 1'b0;
      out_data <= '0;
      skid_data <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (~out_valid | ret) begin
      // a held skid entry implies main stays valid, so only the data moves
      if (skid_valid) begin
        out_data <= skid_data;
        skid_valid <= 1'b0;
      end else begin
        out_valid <= acc;
        if (acc) out_data <= in_data;
      end
    end else if (acc) begin
      skid_valid <= 1'b1;
      skid_data <= in_data;
    end
  end
endmodule

// File: rtl/exe_mem_skid_reg.sv
// exe_mem_skid_reg: EX/MEM stage register with skid buffer, rw==0 squash and bubble masking.
// Optional saturating stall counter enabled by defining STALL_CNT_EN.
module exe_mem_skid_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int RW_W = 5,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_alu_out,
  input  logic [DATA_W-1:0] in_store_data,
  input  logic [RW_W-1:0]   in_rw,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_alu_out,
  output logic [DATA_W-1:0] out_store_data,
  output logic [RW_W-1:0]   out_rw,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_count
);
  typedef struct packed {
    logic [DATA_W-1:0] alu_out;
    logic [DATA_W-1:0] store_data;
    logic [RW_W-1:0] rw;
    logic [CTRL_W-1:0] ctrl;
  } bundle_t;
  bundle_t d, q;
  always_comb begin
    d = '{alu_out: in_alu_out, store_data: in_store_data, rw: in_rw, ctrl: in_ctrl};
    d.ctrl[CTRL_REGWRITE] = in_ctrl[CTRL_REGWRITE] & (|in_rw);
  end
  skid_buffer_2 #(.W($bits(bundle_t))) u_buf (
    .clk(clk),
    .rst(Reset),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(d),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(q)
  );
  assign out_alu_out = q.alu_out;
  assign out_store_data = q.store_data;
  assign out_rw = q.rw;
  assign out_ctrl = out_valid ? q.ctrl : '0;
`ifdef STALL_CNT_EN
  logic [CNT_W-1:0] cnt;
  always_ff @(negedge clk or posedge Reset) begin
    if (Reset) cnt <= '0;
    else if (out_valid & ~out_ready & ~&cnt) cnt <= cnt + 1'b1;
  end
  assign stall_count = cnt;
`else
  assign stall_count = '0;
`endif
endmodule

// File: tb/tb_exe_mem_skid_reg.sv
// tb_exe_mem_skid_reg: directed checks of handshake, ordering, squash, flush, reset and stall count.
module tb_exe_mem_skid_reg;
  logic clk = 1'b1;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [31:0] in_alu_out = '0;
  logic [31:0] in_store_data = '0;
  logic [4:0] in_rw = '0;
  logic [4:0] in_ctrl = '0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [31:0] out_alu_out;
  logic [31:0] out_store_data;
  logic [4:0] out_rw;
  logic [4:0] out_ctrl;
  logic [3:0] stall_count;
  int total = 0;
  int bad = 0;
`ifdef STALL_CNT_EN
  localparam logic [3:0] SAT = 4'hf;
`else
  localparam logic [3:0] SAT = 4'h0;
`endif
  always #5 clk = ~clk;
  exe_mem_skid_reg #(.DATA_W(32), .RW_W(5), .CNT_W(4)) dut (
    .clk(clk),
    .Reset(rst),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_alu_out(in_alu_out),
    .in_store_data(in_store_data),
    .in_rw(in_rw),
    .in_ctrl(in_ctrl),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_alu_out(out_alu_out),
    .out_store_data(out_store_data),
    .out_rw(out_rw),
    .out_ctrl(out_ctrl),
    .stall_count(stall_count)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [31:0] a, input logic [4:0] r, input logic [4:0] c);
    in_valid = v;
    in_alu_out = a;
    in_store_data = ~a;
    in_rw = r;
    in_ctrl = c;
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_ov"}, 32'(out_valid), 32'd0);
    chk({tag, "_ir"}, 32'(in_ready), 32'd1);
    chk({tag, "_ctrl"}, 32'(out_ctrl), 32'd0);
    chk({tag, "_alu"}, out_alu_out, 32'd0);
    chk({tag, "_sd"}, out_store_data, 32'd0);
    chk({tag, "_rw"}, 32'(out_rw), 32'd0);
    chk({tag, "_sc"}, 32'(stall_count), 32'd0);
  endtask
  initial begin
    #1;
    chk_reset("rst0");
    #1 rst = 1'b0;
    // pass-through
    out_ready = 1'b1;
    drive(1'b1, 32'h0000_1234, 5'd8, 5'b00011);
    tick();
    chk("pt_ov", 32'(out_valid), 32'd1);
    chk("pt_alu", out_alu_out, 32'h0000_1234);
    chk("pt_sd", out_store_data, ~32'h0000_1234);
    chk("pt_rw", 32'(out_rw), 32'd8);
    chk("pt_ctrl", 32'(out_ctrl), 32'b00011);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'h100 + i, 5'(i + 1), 5'b01001);
      tick();
      chk("b2b_alu", out_alu_out, 32'h100 + i);
      chk("b2b_ir", 32'(in_ready), 32'd1);
    end
    drive(1'b0, 32'h0, 5'd0, 5'd0);
    tick();
    chk("drain_ov", 32'(out_valid), 32'd0);
    chk("drain_ctrl", 32'(out_ctrl), 32'd0);
    // back-pressure
    out_ready = 1'b0;
    drive(1'b1, 32'hA, 5'd2, 5'b00001);
    tick();
    chk("bp_a_ir", 32'(in_ready), 32'd1);
    chk("bp_a_alu", out_alu_out, 32'hA);
    drive(1'b1, 32'hB, 5'd3, 5'b00001);
    tick();
    chk("bp_full_ir", 32'(in_ready), 32'd0);
    chk("bp_full_alu", out_alu_out, 32'hA);
    drive(1'b1, 32'hC, 5'd4, 5'b00001);
    tick();
    chk("bp_hold_ir", 32'(in_ready), 32'd0);
    chk("bp_hold_alu", out_alu_out, 32'hA);
    out_ready = 1'b1;
    tick();
    chk("bp_b_alu", out_alu_out, 32'hB);
    chk("bp_b_rw", 32'(out_rw), 32'd3);
    chk("bp_b_ir", 32'(in_ready), 32'd1);
    tick();
    chk("bp_c_alu", out_alu_out, 32'hC);
    chk("bp_c_ov", 32'(out_valid), 32'd1);
    drive(1'b0, 32'h0, 5'd0, 5'd0);
    tick();
    chk("bp_end_ov", 32'(out_valid), 32'd0);
    // register-0 squash
    drive(1'b1, 32'h20, 5'd0, 5'b00001);
    tick();
    chk("sq_r0_ov", 32'(out_valid), 32'd1);
    chk("sq_r0_ctrl", 32'(out_ctrl), 32'b00000);
    drive(1'b1, 32'h21, 5'd1, 5'b00001);
    tick();
    chk("sq_r1_ctrl", 32'(out_ctrl), 32'b00001);
    drive(1'b1, 32'h22, 5'd0, 5'b11011);
    tick();
    chk("sq_keep_ctrl", 32'(out_ctrl), 32'b11010);
    // flush while ONE drops the same-edge accept
    drive(1'b1, 32'h30, 5'd5, 5'b01000);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 5'd0, 5'd0);
    chk("fl1_ov", 32'(out_valid), 32'd0);
    chk("fl1_ctrl", 32'(out_ctrl), 32'd0);
    // stall counting, then flush from FULL
    out_ready = 1'b0;
    drive(1'b1, 32'h40, 5'd6, 5'b01000);
    tick();
    drive(1'b0, 32'h0, 5'd0, 5'd0);
    for (int i = 0; i < 20; i++) tick();
    chk("sc_sat", 32'(stall_count), 32'(SAT));
    chk("sc_hold_alu", out_alu_out, 32'h40);
    drive(1'b1, 32'h41, 5'd7, 5'b01000);
    tick();
    chk("fl2_full_ir", 32'(in_ready), 32'd0);
    drive(1'b1, 32'hF, 5'd9, 5'b01000);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 5'd0, 5'd0);
    chk("fl2_ov", 32'(out_valid), 32'd0);
    chk("fl2_ctrl", 32'(out_ctrl), 32'd0);
    chk("fl2_ir", 32'(in_ready), 32'd1);
    chk("fl2_sc", 32'(stall_count), 32'(SAT));
    out_ready = 1'b1;
    tick();
    chk("fl2_gone_ov", 32'(out_valid), 32'd0);
    // refill to FULL, then asynchronous reset between edges
    out_ready = 1'b0;
    drive(1'b1, 32'h50, 5'd10, 5'b01111);
    tick();
    drive(1'b1, 32'h51, 5'd11, 5'b01111);
    tick();
    drive(1'b0, 32'h0, 5'd0, 5'd0);
    chk("ar_full_ir", 32'(in_ready), 32'd0);
    chk("ar_full_ctrl", 32'(out_ctrl), 32'b01111);
    #2 rst = 1'b1;
    #1;
    chk_reset("rst1");
    #1 rst = 1'b0;
    tick();
    chk("post_rst_ov", 32'(out_valid), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
